// File: rtl/seg_pkg.sv
// Shared seven-segment definitions: segment codes, digit-enable patterns,
// frame layout and decode helpers used by both display driver and capture.
package seg_pkg;

  localparam int unsigned SEG_W   = 7;
  localparam int unsigned EN_W    = 8;
  localparam int unsigned DIGIT_W = 4;
  localparam int unsigned POS_W   = 3;
  localparam int unsigned NUM_POS = 6;
  localparam int unsigned FRAME_W = NUM_POS * DIGIT_W;
  localparam int unsigned CNT_W   = 8;

  // Active-low segment codes, bit6 = a ... bit0 = g
  localparam logic [SEG_W-1:0] SEG_0     = 7'b0000001;
  localparam logic [SEG_W-1:0] SEG_1     = 7'b1001111;
  localparam logic [SEG_W-1:0] SEG_2     = 7'b0010010;
  localparam logic [SEG_W-1:0] SEG_3     = 7'b0000110;
  localparam logic [SEG_W-1:0] SEG_4     = 7'b1001100;
  localparam logic [SEG_W-1:0] SEG_5     = 7'b0100100;
  localparam logic [SEG_W-1:0] SEG_6     = 7'b0100000;
  localparam logic [SEG_W-1:0] SEG_7     = 7'b0001111;
  localparam logic [SEG_W-1:0] SEG_8     = 7'b0000000;
  localparam logic [SEG_W-1:0] SEG_9     = 7'b0000100;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

  // Active-low one-hot digit enables
  localparam logic [EN_W-1:0] EN_SEC1  = 8'b1111_1110;
  localparam logic [EN_W-1:0] EN_SEC2  = 8'b1111_1101;
  localparam logic [EN_W-1:0] EN_MIN1  = 8'b1111_1011;
  localparam logic [EN_W-1:0] EN_MIN2  = 8'b1111_0111;
  localparam logic [EN_W-1:0] EN_HOUR1 = 8'b1110_1111;
  localparam logic [EN_W-1:0] EN_HOUR2 = 8'b1101_1111;

  localparam logic [POS_W-1:0] POS_SEC1  = 3'd0;
  localparam logic [POS_W-1:0] POS_SEC2  = 3'd1;
  localparam logic [POS_W-1:0] POS_MIN1  = 3'd2;
  localparam logic [POS_W-1:0] POS_MIN2  = 3'd3;
  localparam logic [POS_W-1:0] POS_HOUR1 = 3'd4;
  localparam logic [POS_W-1:0] POS_HOUR2 = 3'd5;

  typedef enum logic [1:0] {
    ST_WAIT    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_HOLD    = 2'd3
  } cap_state_t;

  typedef struct packed {
    logic               valid;
    logic [DIGIT_W-1:0] digit;
  } seg_dec_t;

  typedef struct packed {
    logic             valid;
    logic [POS_W-1:0] pos;
  } pos_dec_t;

  // Segment pattern to BCD digit; anything outside 0-9 is invalid
  function automatic seg_dec_t seg_decode(input logic [SEG_W-1:0] s);
    seg_dec_t d;
    d.valid = 1'b1;
    d.digit = '0;
    case (s)
      SEG_0:     d.digit = 4'd0;
      SEG_1:     d.digit = 4'd1;
      SEG_2:     d.digit = 4'd2;
      SEG_3:     d.digit = 4'd3;
      SEG_4:     d.digit = 4'd4;
      SEG_5:     d.digit = 4'd5;
      SEG_6:     d.digit = 4'd6;
      SEG_7:     d.digit = 4'd7;
      SEG_8:     d.digit = 4'd8;
      SEG_9:     d.digit = 4'd9;
      SEG_BLANK: d.valid = 1'b0;
      default:   d.valid = 1'b0;
    endcase
    return d;
  endfunction

  // Digit-enable pattern to frame position; any other pattern is idle
  function automatic pos_dec_t pos_decode(input logic [EN_W-1:0] en);
    pos_dec_t p;
    p.valid = 1'b1;
    p.pos   = '0;
    case (en)
      EN_SEC1:  p.pos = POS_SEC1;
      EN_SEC2:  p.pos = POS_SEC2;
      EN_MIN1:  p.pos = POS_MIN1;
      EN_MIN2:  p.pos = POS_MIN2;
      EN_HOUR1: p.pos = POS_HOUR1;
      EN_HOUR2: p.pos = POS_HOUR2;
      default:  p.valid = 1'b0;
    endcase
    return p;
  endfunction

  // Frame is {hour2, hour1, min2, min1, sec2, sec1}; flags non-12-hour times
  function automatic logic frame_range_err(input logic [FRAME_W-1:0] f);
    logic [DIGIT_W-1:0] sec2;
    logic [DIGIT_W-1:0] min2;
    logic [DIGIT_W-1:0] hour1;
    logic [DIGIT_W-1:0] hour2;
    sec2  = f[1*DIGIT_W +: DIGIT_W];
    min2  = f[3*DIGIT_W +: DIGIT_W];
    hour1 = f[4*DIGIT_W +: DIGIT_W];
    hour2 = f[5*DIGIT_W +: DIGIT_W];
    return (sec2 > 4'd5) || (min2 > 4'd5) || (hour2 > 4'd1) ||
           ((hour2 == 4'd1) && (hour1 > 4'd1));
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational active-low segment pattern to BCD digit with valid flag.
module seg7_decode
  import seg_pkg::*;
(
  input  logic [SEG_W-1:0]   seg,
  output logic               valid_c,
  output logic [DIGIT_W-1:0] digit_c
);

  seg_dec_t dec_c;

  // Table lookup shared with the display driver
  always_comb begin
    dec_c   = seg_decode(seg);
    valid_c = dec_c.valid;
    digit_c = dec_c.digit;
  end

endmodule

// File: rtl/seg_scan_capture.sv
// Captures a scanned multiplexed seven-segment display back into a BCD frame.
module seg_scan_capture
  import seg_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [EN_W-1:0]    disp_en,
  input  logic [SEG_W-1:0]   seg,
  output logic [FRAME_W-1:0] time_bcd,
  output logic               frame_valid,
  output logic               code_err,
  output logic               range_err
);

  logic [EN_W-1:0]    en_s1, en_s2, en_q;
  logic [SEG_W-1:0]   seg_s1, seg_s2, seg_q;
  cap_state_t         state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n, cnt_inc_c;
  logic               pair_chg_c;
  logic               cap_c;
  pos_dec_t           pos_cur_c, pos_q_c;
  logic               dig_valid_c;
  logic [DIGIT_W-1:0] dig_c;
  logic [NUM_POS-1:0] mask, mask_wr_c;
  logic [FRAME_W-1:0] hold, hold_wr_c;

  // Two-flop synchronizers plus previous-pair register for change detection
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      en_s1  <= '1;
      en_s2  <= '1;
      en_q   <= '1;
      seg_s1 <= '1;
      seg_s2 <= '1;
      seg_q  <= '1;
    end else begin
      en_s1  <= disp_en;
      en_s2  <= en_s1;
      en_q   <= en_s2;
      seg_s1 <= seg;
      seg_s2 <= seg_s1;
      seg_q  <= seg_s2;
    end
  end

  // en_q/seg_q hold the pair that was stable through the settle window
  always_comb begin
    pos_cur_c  = pos_decode(en_s2);
    pos_q_c    = pos_decode(en_q);
    pair_chg_c = ({en_s2, seg_s2} != {en_q, seg_q});
    cnt_inc_c  = (cnt == '1) ? cnt : cnt + CNT_W'(1);
  end

  seg7_decode u_decode (
    .seg     (seg_q),
    .valid_c (dig_valid_c),
    .digit_c (dig_c)
  );

  // FSM state and saturating settle counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_WAIT;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // Next-state: one capture per stable dwell of the synchronized pair
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    cap_c   = 1'b0;
    case (state)
      ST_WAIT: begin
        cnt_n = '0;
        if (pos_cur_c.valid) state_n = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (!pos_cur_c.valid) begin
          state_n = ST_WAIT;
          cnt_n   = '0;
        end else if (pair_chg_c) begin
          cnt_n = '0;
        end else begin
          cnt_n = cnt_inc_c;
          if (cnt_inc_c >= CNT_W'(SETTLE_CYCLES)) state_n = ST_CAPTURE;
        end
      end
      ST_CAPTURE, ST_HOLD: begin
        cap_c = (state == ST_CAPTURE) && pos_q_c.valid;
        if (!pos_cur_c.valid) begin
          state_n = ST_WAIT;
          cnt_n   = '0;
        end else if (pair_chg_c) begin
          state_n = ST_SETTLE;
          cnt_n   = '0;
        end else begin
          state_n = ST_HOLD;
          cnt_n   = cnt_inc_c;
        end
      end
      default: state_n = ST_WAIT;
    endcase
  end

  // Holding register and mask contents after a valid capture
  always_comb begin
    hold_wr_c = hold;
    hold_wr_c[32'(pos_q_c.pos) * DIGIT_W +: DIGIT_W] = dig_c;
    mask_wr_c = mask | (NUM_POS'(1) << pos_q_c.pos);
  end

  // Frame assembly, publication and error pulses
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold        <= '0;
      mask        <= '0;
      time_bcd    <= '0;
      frame_valid <= 1'b0;
      code_err    <= 1'b0;
      range_err   <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      code_err    <= 1'b0;
      range_err   <= 1'b0;
      if (cap_c) begin
        if (!dig_valid_c) begin
          code_err <= 1'b1;
          mask     <= '0;
          hold     <= '0;
        end else if (mask_wr_c == '1) begin
          hold        <= hold_wr_c;
          time_bcd    <= hold_wr_c;
          frame_valid <= 1'b1;
          range_err   <= frame_range_err(hold_wr_c);
          mask        <= '0;
        end else begin
          hold <= hold_wr_c;
          mask <= mask_wr_c;
        end
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_capture.sv
// Directed and randomized scans against a frame-level reference model.
module tb_seg_scan_capture;

  localparam int unsigned S    = 8;
  localparam int          LONG = 20;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  disp_en = 8'hFF;
  logic [6:0]  seg = 7'h7F;
  logic [23:0] time_bcd;
  logic        frame_valid, code_err, range_err;

  seg_scan_capture #(.SETTLE_CYCLES(S)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .disp_en     (disp_en),
    .seg         (seg),
    .time_bcd    (time_bcd),
    .frame_valid (frame_valid),
    .code_err    (code_err),
    .range_err   (range_err)
  );

  always #5 clk = ~clk;

  logic [7:0] en_tab [6]    = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF};
  logic [6:0] code_tab [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                                7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                                7'b0000000, 7'b0000100};
  logic [7:0] idle_tab [6]  = '{8'hFF, 8'hFC, 8'h7F, 8'hBF, 8'h00, 8'hF0};

  int unsigned compared = 0;
  int unsigned mismatched = 0;

  // Observed pulse counts, sampled away from the active edge
  int unsigned fv_cnt = 0, ce_cnt = 0, re_cnt = 0, re_alone = 0, rst_bad = 0;
  logic [23:0] last_time = '0;

  always @(negedge clk) begin
    if (reset_n) begin
      if (frame_valid) begin
        fv_cnt++;
        last_time = time_bcd;
      end
      if (code_err) ce_cnt++;
      if (range_err) begin
        re_cnt++;
        if (!frame_valid) re_alone++;
      end
    end else if (frame_valid || code_err || range_err || time_bcd != 24'h0) begin
      rst_bad++;
    end
  end

  // Reference model state: digits seen per position since last frame/error
  int          m_digit [6];
  bit          m_have [6];
  int unsigned exp_fv = 0, exp_ce = 0, exp_re = 0, exp_time = 0;
  logic [7:0]  prev_en = 8'hFF;
  logic [6:0]  prev_sg = 7'h7F;

  task automatic model_clear();
    for (int i = 0; i < 6; i++) begin
      m_have[i]  = 1'b0;
      m_digit[i] = 0;
    end
  endtask

  task automatic model_apply(input logic [7:0] en, input logic [6:0] sg);
    int p = -1;
    int d = -1;
    bit all;
    for (int i = 0; i < 6; i++) if (en == en_tab[i]) p = i;
    if (p < 0) return;
    for (int i = 0; i < 10; i++) if (sg == code_tab[i]) d = i;
    if (d < 0) begin
      exp_ce++;
      model_clear();
      return;
    end
    m_digit[p] = d;
    m_have[p]  = 1'b1;
    all = 1'b1;
    for (int i = 0; i < 6; i++) if (!m_have[i]) all = 1'b0;
    if (all) begin
      exp_fv++;
      exp_time = 0;
      for (int i = 5; i >= 0; i--) exp_time = exp_time * 16 + m_digit[i];
      if (m_digit[1] > 5 || m_digit[3] > 5 || m_digit[5] > 1 ||
          (m_digit[5] == 1 && m_digit[4] > 1))
        exp_re++;
      for (int i = 0; i < 6; i++) m_have[i] = 1'b0;
    end
  endtask

  task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, "/frame_valid_count"}, fv_cnt, exp_fv);
    check({tag, "/code_err_count"}, ce_cnt, exp_ce);
    check({tag, "/range_err_count"}, re_cnt, exp_re);
    check({tag, "/time_bcd"}, 32'(last_time), exp_time);
  endtask

  // Hold one pair on the pins for dwell cycles, then update the model
  task automatic step(input logic [7:0] en, input logic [6:0] sg, input int dwell);
    @(negedge clk);
    disp_en = en;
    seg     = sg;
    prev_en = en;
    prev_sg = sg;
    repeat (dwell - 1) @(negedge clk);
    #2;
    if (dwell >= LONG) model_apply(en, sg);
  endtask

  // Full scan sec1..hour2 with digits given hour2 first
  task automatic scan(input int h2, input int h1, input int m2, input int m1,
                      input int s2, input int s1);
    int dg [6];
    dg = '{s1, s2, m1, m2, h1, h2};
    for (int i = 0; i < 6; i++) step(en_tab[i], code_tab[dg[i]], LONG);
  endtask

  initial begin
    logic [7:0] en;
    logic [6:0] sg;
    int         dwell;
    int         r;

    model_clear();
    repeat (4) @(negedge clk);
    check("reset/time_bcd", 32'(time_bcd), 0);
    check("reset/frame_valid", 32'(frame_valid), 0);
    check("reset/code_err", 32'(code_err), 0);
    check("reset/range_err", 32'(range_err), 0);
    reset_n = 1'b1;

    scan(1, 2, 3, 4, 5, 6);
    check_all("scan_123456");
    check("scan_123456/literal", 32'(last_time), 32'h123456);

    scan(1, 1, 5, 9, 5, 9);
    check_all("scan_115959");
    scan(1, 3, 0, 0, 0, 0);
    check_all("scan_130000");
    check("scan_130000/re_with_fv", re_alone, 0);

    // Short dwell on position 2 must not capture
    step(en_tab[0], code_tab[8], LONG);
    step(en_tab[1], code_tab[4], LONG);
    step(en_tab[2], code_tab[3], S - 1);
    step(en_tab[3], code_tab[2], LONG);
    step(en_tab[4], code_tab[0], LONG);
    step(en_tab[5], code_tab[1], LONG);
    check_all("short_dwell");
    step(en_tab[2], code_tab[3], LONG);
    check_all("short_dwell_rescan");

    // Invalid segment pattern
    step(en_tab[0], code_tab[1], LONG);
    step(en_tab[1], code_tab[2], LONG);
    step(en_tab[2], code_tab[3], LONG);
    step(en_tab[3], 7'b1111110, LONG);
    check_all("code_err");
    scan(0, 9, 4, 5, 3, 7);
    check_all("after_code_err");

    // Idle patterns interleaved between digits
    for (int i = 0; i < 6; i++) begin
      step(en_tab[i], code_tab[(i * 3 + 1) % 10], LONG);
      step((i % 2) ? 8'hFC : 8'hFF, code_tab[5], 4);
    end
    check_all("idle_interleave");

    // Very long dwell: exactly one capture despite counter saturation
    step(en_tab[0], code_tab[7], 300);
    scan(1, 0, 2, 5, 4, 7);
    check_all("long_dwell");

    // Reset mid-frame
    for (int i = 0; i < 4; i++) step(en_tab[i], code_tab[i + 2], LONG);
    @(negedge clk);
    disp_en = 8'hFF;
    prev_en = 8'hFF;
    #1 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    check("midreset/time_bcd", 32'(time_bcd), 0);
    check("midreset/frame_valid", 32'(frame_valid), 0);
    model_clear();
    exp_time  = 0;
    last_time = '0;
    reset_n = 1'b1;
    step(en_tab[4], code_tab[1], LONG);
    step(en_tab[5], code_tab[0], LONG);
    check_all("post_reset_partial");
    for (int i = 0; i < 4; i++) step(en_tab[i], code_tab[9 - i], LONG);
    check_all("post_reset_frame");

    // Randomized scans
    for (int n = 0; n < 160; n++) begin
      r = $urandom_range(0, 99);
      if (r < 60) begin
        en = en_tab[$urandom_range(0, 5)];
        sg = ($urandom_range(0, 19) == 0) ? 7'($urandom) : code_tab[$urandom_range(0, 9)];
        dwell = $urandom_range(LONG, LONG + 10);
      end else if (r < 75) begin
        en = en_tab[$urandom_range(0, 5)];
        sg = code_tab[$urandom_range(0, 9)];
        dwell = $urandom_range(1, S - 1);
      end else begin
        en = ($urandom_range(0, 3) == 0) ? 8'($urandom) : idle_tab[$urandom_range(0, 5)];
        sg = 7'($urandom);
        dwell = $urandom_range(1, 6);
      end
      if (en == prev_en && sg == prev_sg) sg = sg ^ 7'h40;
      step(en, sg, dwell);
      check_all($sformatf("rand%0d", n));
    end

    check("final/range_err_alone", re_alone, 0);
    check("final/reset_activity", rst_bad, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
